// File: rtl/sparse_xor_accum_pp_pkg.sv
// rtl/sparse_xor_accum_pp_pkg.sv - shared types and constants for sparse_xor_accum_pp
// Purpose : read-side state encoding and the width of the frame counter.
// Ports   : none (package).
package sparse_mult_pkg;

  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PING  = 2'd1,
    ST_PONG  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/sparse_xor_accum_pp_word_buffer.sv
// rtl/sparse_xor_accum_pp_word_buffer.sv - two-entry ping-pong result store
// Purpose : holds up to two finished frame results. Writes alternate ping,
//           pong, ping...; reads drain them in the same order.
// Ports   : i_clock, i_reset_n     clock, async active-low reset
//           i_wr_en, i_wr_data     store a result into the entry at the write pointer
//           i_rd_en                release the entry at the read pointer
//           o_ping_data/o_pong_data entry contents
//           o_full[1:0]            per-entry occupancy (bit 0 ping, bit 1 pong)
//           o_wr_ptr               entry the next write lands in (0 ping, 1 pong)
module pp_word_buffer #(
  parameter int WIDTH = 96
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_ping_data,
  output logic [WIDTH-1:0] o_pong_data,
  output logic [1:0]       o_full,
  output logic             o_wr_ptr
);

  logic [WIDTH-1:0] r_ping;
  logic [WIDTH-1:0] r_pong;
  logic [1:0]       r_full;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       w_full_next;

  // A read and a write in the same cycle always target different entries,
  // so clearing first and then setting is order-independent.
  always_comb begin
    w_full_next = r_full;
    if (i_rd_en) w_full_next[r_rd_ptr] = 1'b0;
    if (i_wr_en) w_full_next[r_wr_ptr] = 1'b1;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ping   <= '0;
      r_pong   <= '0;
      r_full   <= 2'b00;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (i_wr_en) begin
        if (r_wr_ptr) r_pong <= i_wr_data;
        else          r_ping <= i_wr_data;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (i_rd_en) r_rd_ptr <= ~r_rd_ptr;
      r_full <= w_full_next;
    end
  end

  assign o_ping_data = r_ping;
  assign o_pong_data = r_pong;
  assign o_full      = r_full;
  assign o_wr_ptr    = r_wr_ptr;

endmodule

// File: rtl/sparse_xor_accum_pp.sv
// rtl/sparse_xor_accum_pp.sv - per-frame masked XOR reduction with ping-pong output
// Purpose : XORs the MASK-selected words of each FRAME_LEN-word frame (or passes
//           the last word when PASS_LAST=1) and queues the result in a two-entry
//           ping-pong buffer drained over a valid/ready handshake.
// Ports   : i_clock, i_reset_n               clock, async active-low reset
//           i_input_data/valid, o_input_ready input word handshake
//           o_output_data/valid, i_output_ready result handshake
//           o_frame_count                     results delivered since reset (wraps)
module sparse_xor_accum_pp
  import sparse_mult_pkg::*;
#(
  parameter int                   WIDTH     = 96,
  parameter int                   FRAME_LEN = 11,
  parameter logic [FRAME_LEN-1:0] MASK      = '1,
  parameter int                   PASS_LAST = 0
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [WIDTH-1:0]       i_input_data,
  input  logic                   i_input_valid,
  output logic                   o_input_ready,
  output logic [WIDTH-1:0]       o_output_data,
  output logic                   o_output_valid,
  input  logic                   i_output_ready,
  output logic [FRAME_CNT_W-1:0] o_frame_count
);

  localparam int             IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [IDX_W-1:0]       r_index;
  logic [WIDTH-1:0]       r_acc;
  logic                   r_run;
  rd_state_t              r_state;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  logic             w_last;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_masked;
  logic [WIDTH-1:0] w_final;
  logic [WIDTH-1:0] w_ping_data;
  logic [WIDTH-1:0] w_pong_data;
  logic [1:0]       w_full;
  logic             w_wr_ptr;

  assign w_last     = (r_index == LAST_IDX);
  // Only the frame-closing word needs a free buffer; r_run keeps ready low
  // through reset and the first edge after release. All terms are registers.
  assign o_input_ready = r_run & ~(w_last & (&w_full));
  assign w_in_fire  = i_input_valid & o_input_ready;
  assign w_out_fire = o_output_valid & i_output_ready;
  assign w_wr_en    = w_in_fire & w_last;
  assign w_masked   = MASK[r_index] ? i_input_data : '0;
  assign w_final    = (PASS_LAST != 0) ? i_input_data : (r_acc ^ w_masked);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_index <= '0;
      r_acc   <= '0;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_in_fire) begin
        r_index <= w_last ? '0 : r_index + IDX_W'(1);
        if (PASS_LAST != 0) r_acc <= w_last ? i_input_data : '0;
        else                r_acc <= ((r_index == '0) ? '0 : r_acc) ^ w_masked;
      end
    end
  end

  pp_word_buffer #(
    .WIDTH (WIDTH)
  ) u_buf (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_wr_en     (w_wr_en),
    .i_wr_data   (w_final),
    .i_rd_en     (w_out_fire),
    .o_ping_data (w_ping_data),
    .o_pong_data (w_pong_data),
    .o_full      (w_full),
    .o_wr_ptr    (w_wr_ptr)
  );

  // The state names the entry being presented. It follows the write strobe
  // directly (not the registered full flag) so valid appears one cycle after
  // the closing word; a write during a read means the other entry is now due.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_wr_en) r_state <= w_wr_ptr ? ST_PONG : ST_PING;
        ST_PING:  if (w_out_fire) r_state <= (w_full[1] | w_wr_en) ? ST_PONG : ST_EMPTY;
        ST_PONG:  if (w_out_fire) r_state <= (w_full[0] | w_wr_en) ? ST_PING : ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_frame_count <= '0;
    else if (w_out_fire) r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
  end

  assign o_output_valid = (r_state != ST_EMPTY);
  assign o_frame_count  = r_frame_count;

  always_comb begin
    o_output_data = '0;
    case (r_state)
      ST_PING: o_output_data = w_ping_data;
      ST_PONG: o_output_data = w_pong_data;
      default: o_output_data = '0;
    endcase
  end

endmodule

// File: tb/tb_sparse_xor_accum_pp.sv
// tb/tb_sparse_xor_accum_pp.sv - self-checking bench for sparse_xor_accum_pp
module tb_sparse_xor_accum_pp;

  localparam logic [3:0] TB_MASK = 4'b1011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        o_rdy, o_valid, o_rdy_pl, o_valid_pl;
  logic [7:0]  o_data, o_data_pl;
  logic [15:0] o_cnt, o_cnt_pl;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int res_count = 0;
  bit tog_en = 0;
  bit rnd_en = 0;

  sparse_xor_accum_pp #(.WIDTH(8), .FRAME_LEN(4), .MASK(TB_MASK), .PASS_LAST(0)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_input_data(in_data), .i_input_valid(in_valid),
    .o_input_ready(o_rdy), .o_output_data(o_data), .o_output_valid(o_valid),
    .i_output_ready(out_ready), .o_frame_count(o_cnt));

  sparse_xor_accum_pp #(.WIDTH(8), .FRAME_LEN(4), .MASK(TB_MASK), .PASS_LAST(1)) dut_pl (
    .i_clock(clk), .i_reset_n(rst_n), .i_input_data(in_data), .i_input_valid(in_valid),
    .o_input_ready(o_rdy_pl), .o_output_data(o_data_pl), .o_output_valid(o_valid_pl),
    .i_output_ready(out_ready), .o_frame_count(o_cnt_pl));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (tog_en) begin #1; out_ready = ~out_ready; end
    else if (rnd_en) begin #1; out_ready = 1'($urandom_range(0, 1)); end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of words; its result is the XOR of the
  // words whose mask bit is set (or the last word). Results wait in a FIFO of
  // at most two; the closing word stalls only when two are waiting.
  logic [7:0] q[$];
  logic [7:0] q_pl[$];
  logic [7:0] frame_words[$];
  int  m_count = 0;
  bit  m_run = 0;
  bit  prev_hold = 0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ready", o_rdy, 0);
      check("rst_valid", o_valid, 0);
      check("rst_data", o_data, 0);
      check("rst_count", o_cnt, 0);
      q.delete(); q_pl.delete(); frame_words.delete();
      m_count = 0; m_run = 0; prev_hold = 0;
    end else begin
      check("in_ready", o_rdy, m_run && !(frame_words.size() == 3 && q.size() == 2));
      check("in_ready_pl", o_rdy_pl, m_run && !(frame_words.size() == 3 && q_pl.size() == 2));
      check("out_valid", o_valid, q.size() != 0);
      check("out_valid_pl", o_valid_pl, q_pl.size() != 0);
      check("out_data", o_data, (q.size() != 0) ? q[0] : 8'h00);
      check("out_data_pl", o_data_pl, (q_pl.size() != 0) ? q_pl[0] : 8'h00);
      check("frame_count", o_cnt, m_count[15:0]);
      check("frame_count_pl", o_cnt_pl, m_count[15:0]);
      if (prev_hold) check("hold_stable", o_data, prev_data);
      prev_hold = o_valid && !out_ready;
      prev_data = o_data;
      if (o_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        if (q_pl.size() != 0) void'(q_pl.pop_front());
        m_count++;
        res_count++;
      end
      if (in_valid && o_rdy) begin
        frame_words.push_back(in_data);
        if (frame_words.size() == 4) begin
          logic [7:0] r;
          r = 8'h00;
          for (int k = 0; k < 4; k++) if (TB_MASK[k]) r = r ^ frame_words[k];
          q.push_back(r);
          q_pl.push_back(frame_words[3]);
          frame_words.delete();
        end
      end
      m_run = 1;
    end
  end

  // Called at posedge+1; leaves in_valid high and returns at posedge+1 after the transfer.
  task automatic send_word(input logic [7:0] d);
    int n;
    n = 0;
    in_data = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!o_rdy && n < 200) begin n++; @(negedge clk); end
    check("send_ready", o_rdy, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin n++; @(negedge clk); end
    check("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0][7:0] w;
    logic [7:0]      exp_xor;
    logic [7:0]      exp_last;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, r0;
    vecs[0] = '{w: '{8'h08, 8'h04, 8'h02, 8'h01}, exp_xor: 8'h0B, exp_last: 8'h08};
    vecs[1] = '{w: '{8'h55, 8'hAA, 8'h00, 8'hFF}, exp_xor: 8'hAA, exp_last: 8'h55};
    vecs[2] = '{w: '{8'h78, 8'h56, 8'h34, 8'h12}, exp_xor: 8'h5E, exp_last: 8'h78};
    vecs[3] = '{w: '{8'h10, 8'h20, 8'h40, 8'h80}, exp_xor: 8'hD0, exp_last: 8'h10};

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors, output ready high: latency 1, count steps per result.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) send_word(vecs[i].w[k]);
      in_valid = 1'b0;
      check("vec_valid", o_valid, 1);
      check("vec_xor", o_data, vecs[i].exp_xor);
      check("vec_last", o_data_pl, vecs[i].exp_last);
      @(posedge clk); #1;
      check("vec_count", o_cnt, i + 1);
      check("vec_idle", o_valid, 0);
    end

    // Backpressure: two results buffered, closing word of frame 3 stalls.
    out_ready = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 4; k++) send_word(8'($urandom));
    for (int k = 0; k < 3; k++) send_word(8'($urandom));
    in_data = 8'($urandom);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_ready_low", o_rdy, 0);
      check("stall_valid", o_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_word(in_data);
    in_valid = 1'b0;
    wait_drain();

    // Sustained streaming: 32 words in 32 cycles, 8 results.
    out_ready = 1'b1;
    t0 = cyc;
    r0 = res_count;
    for (int k = 0; k < 32; k++) send_word(8'($urandom));
    in_valid = 1'b0;
    check("stream_cycles", cyc - t0, 32);
    wait_drain();
    check("stream_results", res_count - r0, 8);

    // Reset mid-frame discards the partial frame.
    send_word(8'hEE);
    send_word(8'h77);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_data", o_data, 0);
    check("mid_rst_ready", o_rdy, 0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) send_word(vecs[0].w[k]);
    in_valid = 1'b0;
    check("post_rst_xor", o_data, 8'h0B);
    @(posedge clk); #1;
    check("post_rst_count", o_cnt, 1);

    // Toggling output ready: data must hold until accepted.
    tog_en = 1;
    r0 = res_count;
    for (int f = 0; f < 6; f++)
      for (int k = 0; k < 4; k++) begin
        send_word(8'($urandom));
        if ($urandom_range(0, 2) == 0) begin in_valid = 1'b0; @(posedge clk); #1; end
      end
    in_valid = 1'b0;
    wait_drain();
    tog_en = 0;
    check("toggle_results", res_count - r0, 6);

    // Random ready with random input gaps.
    rnd_en = 1;
    r0 = res_count;
    for (int f = 0; f < 10; f++)
      for (int k = 0; k < 4; k++) begin
        send_word(8'($urandom));
        if ($urandom_range(0, 3) == 0) begin in_valid = 1'b0; @(posedge clk); #1; end
      end
    in_valid = 1'b0;
    wait_drain();
    rnd_en = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    check("random_results", res_count - r0, 10);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_xor_accum_pp.md
SPARSE_XOR_ACCUM_PP -- requirements
Module: sparse_xor_accum_pp

Interface
REQ-001 SHALL have parameter WIDTH, default 96: data word width in bits, >=1.
REQ-002 SHALL have parameter FRAME_LEN, default 11: input words per frame, >=2.
REQ-003 SHALL have parameter MASK [FRAME_LEN-1:0], default all ones: bit k set selects frame word k into the sum.
REQ-004 SHALL have parameter PASS_LAST, default 0: 1 makes the output the last word of the frame unchanged, ignoring MASK.
REQ-005 i_clock  input  1  sole clock; all state on rising edge.
REQ-006 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-007 i_input_data  input  WIDTH  frame word.
REQ-008 i_input_valid  input  1  input word present.
REQ-009 o_input_ready  output  1  block accepts the word this cycle.
REQ-010 o_output_data  output  WIDTH  per-frame result.
REQ-011 o_output_valid  output  1  result present.
REQ-012 i_output_ready  input  1  consumer accepts the result this cycle.
REQ-013 o_frame_count  output  16  frames emitted since reset, wraps 0xFFFF->0.

Function
REQ-014 Word transfer SHALL occur on (i_input_valid & o_input_ready); result transfer on (o_output_valid & i_output_ready).
REQ-015 An index counter 0..FRAME_LEN-1 SHALL advance on each input transfer and wrap to 0 after FRAME_LEN-1.
REQ-016 A running accumulator SHALL clear at index 0 and XOR in each transferred word whose MASK bit is set; PASS_LAST=1 SHALL instead capture the index FRAME_LEN-1 word.
REQ-017 On transfer of index FRAME_LEN-1, the final value (accumulator XOR masked last word) SHALL be written into the free one of two output buffers, ping then pong alternately.
REQ-018 o_output_valid SHALL rise the cycle after the last-word transfer (latency 1); buffers SHALL be read in write order.
REQ-019 While o_output_valid=1 and i_output_ready=0, o_output_data SHALL hold stable; o_output_data SHALL be 0 when o_output_valid=0.
REQ-020 o_input_ready SHALL be 1 except when index=FRAME_LEN-1 and both buffers are full; it SHALL NOT depend combinationally on i_output_ready.
REQ-021 Words at indices < FRAME_LEN-1 SHALL be accepted even with both buffers full.
REQ-022 Simultaneous last-word write and result read SHALL both complete in one cycle, with correct full flags and order.
REQ-023 Sustained valid/ready both high SHALL give one word/cycle input and one result per FRAME_LEN cycles, no bubbles.
REQ-024 Read FSM states SHALL be ST_EMPTY, ST_PING, ST_PONG: ST_EMPTY->ST_PING/ST_PONG when the next buffer in order fills; ST_PING->ST_PONG on read if pong full, else ST_EMPTY; ST_PONG symmetric.
REQ-025 o_frame_count SHALL increment on each result transfer.
REQ-026 XOR arithmetic SHALL be full WIDTH, no carries, no truncation.

Reset
REQ-027 On i_reset_n=0, asynchronously: index=0, accumulator=0, both buffers empty and zero, read FSM=ST_EMPTY, write pointer=ping, o_frame_count=0.
REQ-028 During reset o_output_valid=0, o_output_data=0, o_input_ready=0; o_input_ready=1 from the first clock edge after release.
REQ-029 Reset mid-frame SHALL discard the partial frame and both buffers; no result emitted for it.

Structure
REQ-030 Package sparse_mult_pkg SHALL hold the read-state typedef and the o_frame_count width constant (16).
REQ-031 Sub-module pp_word_buffer (two-entry ping-pong word store: write/read pointers, full flags) SHALL be instantiated once.

Verification (WIDTH=8, FRAME_LEN=4, MASK=4'b1011, PASS_LAST=0 unless noted)
REQ-032 Input 0x01,0x02,0x04,0x08, output ready high -> one result 0x0B one cycle after last word; o_frame_count=1.
REQ-033 PASS_LAST=1, same input -> result 0x08.
REQ-034 Output ready low, three frames streamed -> results 1,2 buffered, o_input_ready low at index 3 of frame 3; ready high -> results emitted in order, then frame 3 completes.
REQ-035 Both high, 8 frames continuous -> 32 input transfers in 32 cycles, 8 results, no o_input_ready drop.
REQ-036 i_reset_n low after 2 words of a frame -> outputs 0 immediately; next 4 words produce a result from those 4 only.
REQ-037 Output ready toggles each cycle during valid -> o_output_data stable until accepted, no result lost or duplicated.
